// File: rtl/toy_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toy_mem_pkg : shared widths, bus encodings and FSM states for toy_mem       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package toy_mem_pkg;

  localparam int c_addr_w     = 30;
  localparam int c_dw_default = 32;

  localparam logic c_drw_wr = 1'b1;
  localparam logic c_drw_rd = 1'b0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/toy_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toy_sram_array : DEPTH x DW storage, one sync write port, two async reads   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module toy_sram_array
  import toy_mem_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = c_dw_default
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  localparam int c_depth = 2 ** AW;

  logic [DW-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/toy_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toy_mem_responder : shared I/D word memory, 1-cycle read latency, zeroing   |
// | sweep after reset and sticky out-of-range error flag.  Rev 1.0              |
// +----------------------------------------------------------------------------+
module toy_mem_responder
  import toy_mem_pkg::*;
#(
  parameter int AW        = 10,
  parameter int DW        = c_dw_default,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IREQ,
  input  logic [c_addr_w-1:0] IADDR,
  output logic [DW-1:0]       INSTR,
  input  logic                DREQ,
  input  logic                DRW,
  input  logic [c_addr_w-1:0] DADDR,
  input  logic [DW-1:0]       DWDATA,
  output logic [DW-1:0]       DRDATA,
  output logic                READY,
  output logic                ERR
);

  localparam logic [AW-1:0] c_cnt_last = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_drdata;
  logic          r_ready;
  logic          r_err;

  logic          w_i_acc;
  logic          w_d_acc;
  logic          w_i_inr;
  logic          w_d_inr;
  logic          w_d_wr;
  logic          w_d_rd;
  logic          w_bypass;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata_i;
  logic [DW-1:0] w_rdata_d;
  logic [DW-1:0] w_fetch;

  assign w_i_acc = IREQ & r_ready;
  assign w_d_acc = DREQ & r_ready;
  assign w_i_inr = (IADDR >> AW) == '0;
  assign w_d_inr = (DADDR >> AW) == '0;
  assign w_d_wr  = w_d_acc & (DRW == c_drw_wr) & w_d_inr;
  assign w_d_rd  = w_d_acc & (DRW == c_drw_rd);

  // Sweep owns the write port until RUN; afterwards only in-range D writes use it.
  assign w_we    = (r_state == ST_INIT) | w_d_wr;
  assign w_waddr = (r_state == ST_INIT) ? r_cnt : DADDR[AW-1:0];
  assign w_wdata = (r_state == ST_INIT) ? '0 : DWDATA;

  // Write-first: a fetch of the word being written this cycle sees the new data.
  assign w_bypass = w_d_wr & (DADDR[AW-1:0] == IADDR[AW-1:0]);
  assign w_fetch  = w_bypass ? DWDATA : w_rdata_i;

  toy_sram_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk       (CLK),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (IADDR[AW-1:0]),
    .o_rdata_a (w_rdata_i),
    .i_raddr_b (DADDR[AW-1:0]),
    .o_rdata_b (w_rdata_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= INIT_ZERO ? ST_INIT : ST_RUN;
      r_cnt    <= '0;
      r_instr  <= '0;
      r_drdata <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == c_cnt_last) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
          if (w_i_acc) begin
            r_instr <= w_i_inr ? w_fetch : '0;
          end
          if (w_d_rd) begin
            r_drdata <= w_d_inr ? w_rdata_d : '0;
          end
          if ((w_i_acc & ~w_i_inr) | (w_d_acc & ~w_d_inr)) begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign INSTR  = r_instr;
  assign DRDATA = r_drdata;
  assign READY  = r_ready;
  assign ERR    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_toy_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_toy_mem_responder : scoreboard bench for toy_mem_responder (AW=4)        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_toy_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IREQ = 1'b0;
  logic [29:0] IADDR = '0;
  logic [31:0] INSTR;
  logic        DREQ = 1'b0;
  logic        DRW = 1'b0;
  logic [29:0] DADDR = '0;
  logic [31:0] DWDATA = '0;
  logic [31:0] DRDATA;
  logic        READY;
  logic        ERR;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] i_q [$];
  logic [31:0] d_q [$];

  toy_mem_responder #(
    .AW        (4),
    .DW        (32),
    .INIT_ZERO (1'b1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .IREQ   (IREQ),
    .IADDR  (IADDR),
    .INSTR  (INSTR),
    .DREQ   (DREQ),
    .DRW    (DRW),
    .DADDR  (DADDR),
    .DWDATA (DWDATA),
    .DRDATA (DRDATA),
    .READY  (READY),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: a request presented at an edge with an expectation queued is checked just after it.
  always @(posedge CLK) begin
    logic [31:0] e;
    if (IREQ && i_q.size() > 0) begin
      e = i_q.pop_front();
      #1;
      chk("instr", INSTR, e);
    end
  end

  always @(posedge CLK) begin
    logic [31:0] e;
    if (DREQ && !DRW && d_q.size() > 0) begin
      e = d_q.pop_front();
      #1;
      chk("drdata", DRDATA, e);
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle();
    IREQ = 1'b0;
    DREQ = 1'b0;
    DRW  = 1'b0;
  endtask

  task automatic dwrite(input logic [29:0] a, input logic [31:0] d);
    DREQ = 1'b1; DRW = 1'b1; DADDR = a; DWDATA = d;
  endtask

  task automatic dread(input logic [29:0] a, input logic [31:0] exp);
    DREQ = 1'b1; DRW = 1'b0; DADDR = a;
    d_q.push_back(exp);
  endtask

  task automatic ifetch(input logic [29:0] a, input logic [31:0] exp);
    IREQ = 1'b1; IADDR = a;
    i_q.push_back(exp);
  endtask

  // Runs the 16-cycle sweep after RST release; optionally pokes a write that must be ignored.
  task automatic sweep(input bit poke);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (poke && c == 1) dwrite(30'd2, 32'hA5A5A5A5);
      if (c == 2) idle();
      #1;
      chk($sformatf("ready_sweep_c%0d", c), {31'd0, READY}, {31'd0, (c == 16)});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    #1;
    chk("rst_ready", {31'd0, READY}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_instr", INSTR, 32'd0);
    chk("rst_drdata", DRDATA, 32'd0);

    step();
    RST = 1'b0;
    sweep(1'b1);
    chk("init_req_err", {31'd0, ERR}, 32'd0);
    chk("init_req_drdata", DRDATA, 32'd0);

    // Every word zero after the sweep, read on both ports
    for (int a = 0; a < 16; a++) begin
      ifetch(30'(a), 32'd0);
      dread(30'(15 - a), 32'd0);
      step();
    end
    idle();
    step();

    // Write then read, DRDATA holds across the write and idle cycles
    dwrite(30'd5, 32'hDEADBEEF);
    step();
    #1;
    chk("hold_on_write", DRDATA, 32'd0);
    dread(30'd5, 32'hDEADBEEF);
    step();
    idle();
    step();
    step();
    #1;
    chk("hold_idle", DRDATA, 32'hDEADBEEF);

    // Collision: fetch sees the data written this same cycle
    dwrite(30'd3, 32'h12345678);
    ifetch(30'd3, 32'h12345678);
    step();
    idle();
    dread(30'd3, 32'h12345678);
    step();
    // Both ports read the same word in one cycle
    ifetch(30'd5, 32'hDEADBEEF);
    dread(30'd5, 32'hDEADBEEF);
    step();
    idle();

    // Out-of-range handling
    dwrite(30'd0, 32'h11111111);
    step();
    idle();
    #1;
    chk("err_before_oor", {31'd0, ERR}, 32'd0);
    dwrite(30'd16, 32'hBAD0BAD0);
    step();
    idle();
    #1;
    chk("err_after_oor_wr", {31'd0, ERR}, 32'd1);
    dread(30'd0, 32'h11111111);
    ifetch(30'h3FFFFFFF, 32'd0);
    step();
    idle();
    dread(30'h20, 32'd0);
    step();
    idle();
    repeat (4) step();
    #1;
    chk("err_sticky", {31'd0, ERR}, 32'd1);

    // Reset clears outputs and ERR; then RST mid-sweep restarts the sweep
    RST = 1'b1;
    #1;
    chk("rst2_err", {31'd0, ERR}, 32'd0);
    chk("rst2_ready", {31'd0, READY}, 32'd0);
    chk("rst2_instr", INSTR, 32'd0);
    step();
    RST = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      #1;
      chk($sformatf("ready_partial_c%0d", c), {31'd0, READY}, 32'd0);
    end
    RST = 1'b1;
    step();
    #1;
    chk("ready_mid_rst", {31'd0, READY}, 32'd0);
    RST = 1'b0;
    sweep(1'b0);

    // Sweep overwrote earlier contents
    ifetch(30'd5, 32'd0);
    dread(30'd3, 32'd0);
    step();
    idle();
    repeat (3) step();

    chk("i_queue_drained", i_q.size(), 32'd0);
    chk("d_queue_drained", d_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
